div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit divider for MIPS DIV/DIVU in the EX stage. It runs alongside the ALU and delivers {HI,LO} to the HI/LO write path.
- Results follow MIPS convention: quotient goes to LO and remainder goes to HI.
- The unit stalls the pipeline while dividing and supports annul on exception flush.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a divide; sampled only in IDLE.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  in  32  dividend (rs); sampled with start_i.
- opdata2_i  in  32  divisor (rt); sampled with start_i.
- annul_i  in  1  abort the in-flight divide (exception/flush).
- result_o  out  64  {remainder, quotient}, i.e. {HI, LO}.
- ready_o  out  1  one-cycle pulse: result_o is valid and must be written to HI/LO.
- stall_o  out  1  EX-stage stall request.

Behaviour:
- Reset (synchronous, rst=1 at the rising edge of clk): state=IDLE, result_o=0, ready_o=0, stall_o=0, iteration counter=0. Reset overrides every other input, including mid-divide.
- States are IDLE, DIVZERO, BUSY and DONE.
- IDLE:
  - start_i=1 and annul_i=0: latch operands and sign mode.
  - divisor==0 -> go to DIVZERO; otherwise -> go to BUSY with count=0.
  - start_i with annul_i=1 in the same cycle is ignored; state stays IDLE.
- Operand preparation on entry to BUSY:
  - Signed mode: take the magnitudes of both operands (two's-complement negate if the sign bit is set).
  - Record qneg = a[31]^b[31] and rneg = a[31].
  - Unsigned mode: operands are used as-is; qneg=rneg=0.
- BUSY:
  - Restoring radix-2 division, one quotient bit per cycle, MSB first.
  - Each cycle uses a 33-bit partial remainder: shift left by one and bring in the next dividend bit.
  - If partial remainder >= divisor: subtract the divisor and set quotient bit 1; else set quotient bit 0.
  - After exactly 32 iterations (count 0..31) -> DONE.
- DIVZERO:
  - 1 cycle, then -> DONE.
  - Fixed result: quotient=32'hFFFF_FFFF, remainder=dividend, in both signed and unsigned mode.
- DONE:
  - Apply sign fix-up: negate the quotient if qneg, negate the remainder if rneg.
  - Register the fixed-up value into result_o and assert ready_o for exactly one cycle.
  - Return to IDLE on the next edge.
- result_o holds its value until the next DONE or reset.
- Timing: with start_i accepted in cycle N, ready_o=1 in cycle N+33 (normal divide) or cycle N+2 (divide by zero). ready_o is 0 in all other cycles.
- stall_o:
  - Combinational: 1 when (state==IDLE & start_i & ~annul_i) or state==BUSY or state==DIVZERO.
  - 0 in DONE, so the pipeline advances in the same cycle it consumes ready_o.
- annul_i in BUSY or DIVZERO:
  - Next state is IDLE; no ready_o pulse; result_o unchanged.
  - stall_o is still driven by the current state during that cycle.
- annul_i in DONE: ready_o is still pulsed, since the result has already been committed. The pipeline is responsible for suppressing the HI/LO write on flush.
- Overflow case -2^31 / -1 (signed):
  - Magnitude quotient is 0x8000_0000; negation is not applied (qneg=0).
  - Result is quotient=0x8000_0000, remainder=0.
  - No exception is raised, matching MIPS, where DIV never traps.
- A start_i arriving in BUSY/DIVZERO/DONE is ignored. The pipeline holds the instruction via stall_o until IDLE.

Decomposition:
- defines.vh additions:
  - `DIV_CONTROL and `DIVU_CONTROL in the existing 5-bit alucontrol space.
  - State encodings `DIV_IDLE, `DIV_ZERO, `DIV_BUSY, `DIV_DONE (2 bits).
  - `DIV_RESULT_READY and `DIV_RESULT_NOT_READY.
- No sub-module is required. Sign fix-up may be an inline function.
- The 64-bit result muxes with the ALU's MULT/MTHI/MTLO hi/lo outputs before the HI/LO register. That mux is outside this block.

Test Plan:
- DIVU 100 / 7 -> after 33 cycles ready_o=1 for 1 cycle; result_o={32'd2, 32'd14}; stall_o=1 for cycles N..N+32.
- DIV -7 / 2 (0xFFFFFFF9, 2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quot -3).
- DIV 0x80000000 / 0xFFFFFFFF -> result_o={32'h0, 32'h80000000}; no hang, no extra pulse.
- DIVU 5 / 0 -> ready_o in cycle N+2; result_o={32'd5, 32'hFFFFFFFF}; stall_o high 2 cycles.
- Start DIVU 0xFFFFFFFF/3, assert annul_i at cycle N+10 -> state IDLE at N+11, no ready_o; previous result_o retained. A new DIVU 9/3 then gives {0, 3}.
- Assert rst at cycle N+20 mid-divide -> next cycle ready_o=0, stall_o=0, result_o=0. Back-to-back divides (start_i re-asserted the cycle after ready_o) each produce correct results.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit.
//   - div_state_e : divider FSM state encoding (2 bits)
//   - DivControl / DivuControl : alucontrol codes that route an instruction to the divider
//   - DivResultReady / DivResultNotReady : levels of the ready_o handshake
package div_unit_pkg;

    localparam int unsigned DivWidth = 32;

    // Divider codes taken from the unused top of the 5-bit alucontrol space.
    localparam logic [4:0] DivControl  = 5'b11000;
    localparam logic [4:0] DivuControl = 5'b11001;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StDivZero = 2'b01,
        StBusy    = 2'b10,
        StDone    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   start_i      - request a divide (accepted only in IDLE and without annul_i)
//   signed_div_i - 1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i    - dividend (rs); sampled with start_i
//   opdata2_i    - divisor (rt); sampled with start_i
//   annul_i      - abort the in-flight divide (BUSY / DIVZERO)
//   result_o     - {remainder, quotient} = {HI, LO}; held until the next result or reset
//   ready_o      - one-cycle pulse while result_o carries a fresh result
//   stall_o      - EX-stage stall request
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);
    import div_unit_pkg::*;

    localparam int unsigned CntW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    div_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    // quo_q starts as the dividend magnitude and is shifted out MSB first while the
    // quotient bits are shifted in from the bottom.
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   den_q;
    logic               qneg_q, rneg_q;
    logic [2*WIDTH-1:0] result_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     partial, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    assign accept    = start_i & ~annul_i;
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    // One restoring step on the 33-bit partial remainder.
    always_comb begin
        partial  = {rem_q, quo_q[WIDTH-1]};
        diff     = partial - {1'b0, den_q};
        ge       = ~diff[WIDTH];
        rem_next = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (opdata2_i == '0) ? StDivZero : StBusy;
                end
            end
            StDivZero: state_d = annul_i ? StIdle : StDone;
            StBusy: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs. stall_o drops in DONE so the pipeline advances while consuming ready_o.
    always_comb begin
        ready_o = DivResultNotReady;
        stall_o = 1'b0;
        unique case (state_q)
            StIdle:            stall_o = accept;
            StDivZero, StBusy: stall_o = 1'b1;
            StDone:            ready_o = DivResultReady;
            default:           ;
        endcase
    end

    // Datapath. The fixed-up result is registered on the edge into DONE so that
    // result_o is already valid during the ready_o cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            den_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        den_q <= opdata2_i;
                        if (opdata2_i == '0) begin
                            // Raw dividend becomes the remainder; no sign fix-up applies.
                            quo_q  <= opdata1_i;
                            qneg_q <= 1'b0;
                            rneg_q <= 1'b0;
                        end else if (signed_div_i) begin
                            quo_q  <= cond_neg(opdata1_i, opdata1_i[WIDTH-1]);
                            den_q  <= cond_neg(opdata2_i, opdata2_i[WIDTH-1]);
                            qneg_q <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
                            rneg_q <= opdata1_i[WIDTH-1];
                        end else begin
                            quo_q  <= opdata1_i;
                            qneg_q <= 1'b0;
                            rneg_q <= 1'b0;
                        end
                    end
                end
                StBusy: begin
                    if (!annul_i) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_iter) begin
                            result_q <= {cond_neg(rem_next, rneg_q), cond_neg(quo_next, qneg_q)};
                        end
                    end
                end
                StDivZero: begin
                    if (!annul_i) begin
                        result_q <= {quo_q, {WIDTH{1'b1}}};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_result = '0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MIPS divide semantics in plain arithmetic.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // Monitor: every ready_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(ready_o), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result_o, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after the
    // edge that leaves DONE, so a following call issues back-to-back.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit annul_done);
        logic [63:0] r;
        int          lat;
        bit          seen;
        bit          stall_ok;
        r   = model(sgn, a, b);
        lat = (b == 0) ? 2 : 33;
        exp_q.push_back('{res: r, cyc: cyc + lat});
        start_i      = 1'b1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        stall_ok     = 1'b1;
        seen         = 1'b0;
        #1;
        if (stall_o !== 1'b1) stall_ok = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            // Noise on start_i while the unit is occupied must be ignored.
            start_i      = 1'($urandom_range(0, 1));
            signed_div_i = 1'($urandom_range(0, 1));
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            #1;
            if (ready_o) begin
                seen = 1'b1;
                if (stall_o !== 1'b0) stall_ok = 1'b0;
                if (annul_done) annul_i = 1'b1;
            end else if (stall_o !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        check("ready_seen", 64'(seen), 64'(1));
        check("stall_profile", 64'(stall_ok), 64'(1));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        last_result = r;
    endtask

    task automatic run_annul(input logic [31:0] a, input logic [31:0] b, input int at);
        int k;
        k = cyc;
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (cyc < k + at) begin
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        #1;
        check("stall_in_annul_cycle", 64'(stall_o), 64'(1));
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        #1;
        check("idle_after_annul", 64'(stall_o), 64'(0));
        repeat (36) @(posedge clk);
        #1;
        check("result_kept", result_o, last_result);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          k;
        rst          = 1'b1;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result_o, 64'h0);
        check("rst_ready", 64'(ready_o), 64'(0));
        check("rst_stall", 64'(stall_o), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7", last_result, {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2", last_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

        // Abort in BUSY, then a fresh divide must still work.
        run_annul(32'hFFFF_FFFF, 32'd3, 10);
        run_div(1'b0, 32'd9, 32'd3, 1'b0);
        check("divu_9_3", last_result, {32'd0, 32'd3});

        // Abort in DIVZERO.
        run_annul(32'd77, 32'd0, 1);

        // start_i together with annul_i is ignored.
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd10;
        opdata2_i = 32'd2;
        #1;
        check("start_annul_stall", 64'(stall_o), 64'(0));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        check("start_annul_idle", 64'(stall_o), 64'(0));
        repeat (3) @(posedge clk);
        #1;

        // annul_i in DONE does not suppress the pulse.
        run_div(1'b1, 32'd1000, 32'hFFFF_FFF6, 1'b1);

        // Randomised back-to-back divides with corner-case biasing.
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_div(1'(n % 2), a, b, 1'b0);
        end

        // Reset mid-divide.
        k = cyc;
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0000_1234;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (cyc < k + 20) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(ready_o), 64'(0));
        check("midrst_stall", 64'(stall_o), 64'(0));
        check("midrst_result", result_o, 64'h0);
        rst = 1'b0;
        last_result = '0;
        @(posedge clk);
        #1;
        run_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("no_outstanding", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
